// File: rtl/sram_burst_ctrl.sv
// Burst initiator for one port of the sram block: write bursts from a valid/ready
// stream, read bursts out through a 4-entry skid FIFO with credit-limited issue.
//
// state  | meaning
// IDLE   | cmd_ready high; accepting a command (read bursts issue their first word here)
// WRITE  | wr_ready high; each beat becomes one SRAM write the following cycle
// READ   | issuing addresses while credits allow; draining FIFO to rd_*
// FINISH | done pulse for one cycle, then back to IDLE
module sram_burst_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int LEN_WIDTH  = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_data,
    output logic                  sram_we,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_FINISH
    } state_t;

    localparam int                    FIFO_DEPTH = 4;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE    = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  remain_q, remain_d;
    logic                  iss_q, iss_d;
    logic                  cap_q, cap_d;
    logic [DATA_WIDTH-1:0] fifo_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_d [FIFO_DEPTH];
    logic [1:0]            wptr_q, wptr_d;
    logic [1:0]            rptr_q, rptr_d;
    logic [2:0]            fifo_cnt_q, fifo_cnt_d;
    logic                  sram_we_q, sram_we_d;
    logic [ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
    logic [DATA_WIDTH-1:0] sram_data_q, sram_data_d;

    logic       cmd_fire;
    logic       push;
    logic       pop;
    logic [2:0] budget;

    // iss_q: address on the SRAM bus this cycle; cap_q: its data is on sram_q this cycle
    assign budget   = fifo_cnt_q + {2'b00, iss_q} + {2'b00, cap_q};
    assign cmd_fire = cmd_valid && (state_q == S_IDLE);
    assign push     = cap_q;
    assign pop      = (fifo_cnt_q != 3'd0) && rd_ready;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remain_d    = remain_q;
        iss_d       = 1'b0;
        sram_we_d   = 1'b0;
        sram_addr_d = sram_addr_q;
        sram_data_d = sram_data_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_fire) begin
                    addr_d   = cmd_addr;
                    remain_d = cmd_len;
                    if (cmd_len == '0) begin
                        state_d = S_FINISH;
                    end else if (cmd_write) begin
                        state_d = S_WRITE;
                    end else begin
                        // First read issues on the handshake edge to hit 3-cycle latency
                        sram_addr_d = cmd_addr;
                        addr_d      = cmd_addr + ADDR_ONE;
                        remain_d    = cmd_len - LEN_ONE;
                        iss_d       = 1'b1;
                        state_d     = S_READ;
                    end
                end
            end
            S_WRITE: begin
                if (wr_valid) begin
                    sram_we_d   = 1'b1;
                    sram_addr_d = addr_q;
                    sram_data_d = wr_data;
                    addr_d      = addr_q + ADDR_ONE;
                    remain_d    = remain_q - LEN_ONE;
                    if (remain_q == LEN_ONE) begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_READ: begin
                if ((remain_q != '0) && (budget < 3'd4)) begin
                    sram_addr_d = addr_q;
                    addr_d      = addr_q + ADDR_ONE;
                    remain_d    = remain_q - LEN_ONE;
                    iss_d       = 1'b1;
                end
                if ((remain_q == '0) && !iss_q && !cap_q && (fifo_cnt_q == 3'd1) && pop) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        cap_d  = iss_q;
        fifo_d = fifo_q;
        if (push) begin
            fifo_d[wptr_q] = sram_q;
        end
        wptr_d     = wptr_q + {1'b0, push};
        rptr_d     = rptr_q + {1'b0, pop};
        fifo_cnt_d = fifo_cnt_q + {2'b00, push} - {2'b00, pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remain_q    <= '0;
            iss_q       <= 1'b0;
            cap_q       <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            fifo_cnt_q  <= '0;
            sram_we_q   <= 1'b0;
            sram_addr_q <= '0;
            sram_data_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remain_q    <= remain_d;
            iss_q       <= iss_d;
            cap_q       <= cap_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
            sram_we_q   <= sram_we_d;
            sram_addr_q <= sram_addr_d;
            sram_data_q <= sram_data_d;
            fifo_q      <= fifo_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_FINISH);
    assign wr_ready  = (state_q == S_WRITE);
    assign rd_valid  = (fifo_cnt_q != 3'd0);
    assign rd_data   = fifo_q[rptr_q];
    assign sram_we   = sram_we_q;
    assign sram_addr = sram_addr_q;
    assign sram_data = sram_data_q;

endmodule
